// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: FSM states and ready/start constants.
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider: 32 shift-subtract edges plus one finalize edge,
// signed/unsigned, result held until the requester drops start_i.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fin_q, fin_d;
    logic [2*DATA_W:0]   wr_q, wr_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0]   op1_abs, op2_abs, quo, rem, quo_fix, rem_fix;
    logic [2*DATA_W:0]   shifted, step;
    logic [DATA_W:0]     partial, diff;
    logic                can_sub;

    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + DATA_W'(1)) : opdata2_i;

        // Partial remainder never exceeds the divisor, so the top bit shifted out is always 0.
        shifted = wr_q << 1;
        partial = shifted[2*DATA_W:DATA_W];
        diff    = partial - {1'b0, divisor_q};
        can_sub = partial >= {1'b0, divisor_q};
        step    = can_sub ? {diff, shifted[DATA_W-1:0] | DATA_W'(1)} : shifted;

        quo     = wr_q[DATA_W-1:0];
        rem     = wr_q[2*DATA_W-1:DATA_W];
        quo_fix = neg_quo_q ? (~quo + DATA_W'(1)) : quo;
        rem_fix = neg_rem_q ? (~rem + DATA_W'(1)) : rem;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fin_d     = fin_q;
        wr_d      = wr_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    wr_d      = {{(DATA_W+1){1'b0}}, op1_abs};
                    divisor_d = op2_abs;
                    neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];
                    cnt_d     = '0;
                    fin_d     = 1'b0;
                    state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end

            // Two edges, mirroring the finalize edge of the normal path.
            DivByZero: begin
                if (annul_i) begin
                    state_d = DivFree;
                    ready_d = DivResultNotReady;
                    result_d = '0;
                end else if (fin_q) begin
                    state_d  = DivEnd;
                    result_d = '0;
                    ready_d  = DivResultReady;
                end else begin
                    fin_d = 1'b1;
                    wr_d  = '0;
                end
            end

            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end else if (fin_q) begin
                    state_d  = DivEnd;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                end else begin
                    wr_d  = step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP)
                        fin_d = 1'b1;
                end
            end

            DivEnd: begin
                if (start_i == DivStop || annul_i) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end
            end

            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            wr_q      <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fin_q     <= fin_d;
            wr_q      <= wr_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: reference results come from SV integer division.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    always #5 clk = ~clk;

    div #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q[$];

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Pushes the expected result, issues the request and waits (bounded) for ready_o.
    // lat = edges after acceptance until ready_o, or -1 on timeout. start_i is left high.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic scramble, output int lat, output logic [63:0] res);
        sb_q.push_back(model(sgn, a, b));
        signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        if (scramble) begin
            opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ready_o) begin lat = n; break; end
        end
        res = result_o;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int lat; logic [63:0] res, exp;
        run_op(1'b0, 32'd100, 32'd7, 1'b0, lat, res);
        exp = sb_q.pop_front();
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL unsigned_latency: got %0d expected 33", lat); end
        checks++;
        if (res !== exp || res !== 64'h00000002_0000000E) begin errors++; $display("FAIL unsigned_100_7: got %h expected %h", res, exp); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready_o !== 1'b1 || result_o !== exp) begin
                errors++; $display("FAIL end_hold: got ready %b result %h expected 1 %h", ready_o, result_o, exp);
            end
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL end_release: got ready %b result %h expected 0 0", ready_o, result_o);
        end
    endtask

    task automatic test_signed();
        logic        sg[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ta[5] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] tb[5] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
        logic [63:0] fixed[5] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'hFFFFFFFF_00000003,
                                  64'h00000000_80000000, 64'h00000000_FFFFFFFF};
        int lat; logic [63:0] res, exp;
        for (int i = 0; i < 5; i++) begin
            run_op(sg[i], ta[i], tb[i], 1'b0, lat, res);
            exp = sb_q.pop_front();
            checks++;
            if (lat !== 33) begin errors++; $display("FAIL signed_latency[%0d]: got %0d expected 33", i, lat); end
            checks++;
            if (res !== exp || res !== fixed[i]) begin errors++; $display("FAIL signed_result[%0d]: got %h expected %h", i, res, fixed[i]); end
            start_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [63:0] res, exp;
        for (int i = 0; i < 2; i++) begin
            run_op(i[0], (i == 0) ? 32'd5 : 32'hFFFFFFFB, 32'd0, 1'b0, lat, res);
            exp = sb_q.pop_front();
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL divzero_latency[%0d]: got %0d expected 2", i, lat); end
            checks++;
            if (res !== exp) begin errors++; $display("FAIL divzero_result[%0d]: got %h expected %h", i, res, exp); end
            start_i = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (ready_o !== 1'b0) begin errors++; $display("FAIL divzero_release[%0d]: got %b expected 0", i, ready_o); end
        end
    endtask

    task automatic test_annul();
        int seen = 0; int lat; logic [63:0] res, exp;
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (ready_o !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", seen); end
        run_op(1'b0, 32'd9, 32'd3, 1'b0, lat, res);
        exp = sb_q.pop_front();
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL annul_next_latency: got %0d expected 33", lat); end
        checks++;
        if (res !== exp || res !== 64'h00000000_00000003) begin errors++; $display("FAIL annul_next_9_3: got %h expected %h", res, exp); end
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] res, exp;
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL reset_mid: got ready %b result %h expected 0 0", ready_o, result_o);
        end
        run_op(1'b1, 32'd1000, 32'hFFFFFFFD, 1'b0, lat, res);
        exp = sb_q.pop_front();
        checks++;
        if (lat !== 33 || res !== exp) begin errors++; $display("FAIL reset_after_op: got lat %0d res %h expected 33 %h", lat, res, exp); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL reset_in_end: got ready %b result %h expected 0 0", ready_o, result_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_operand_change();
        int lat; logic [63:0] res, exp;
        run_op(1'b1, 32'hFFFF1234, 32'd77, 1'b1, lat, res);
        exp = sb_q.pop_front();
        checks++;
        if (lat !== 33 || res !== exp) begin errors++; $display("FAIL operand_change: got lat %0d res %h expected 33 %h", lat, res, exp); end
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] res, exp;
        logic [31:0] a, b; logic sgn;
        for (int i = 0; i < 10; i++) begin
            a   = $urandom;
            b   = (i % 4 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            sgn = 1'($urandom_range(0, 1));
            run_op(sgn, a, b, 1'b0, lat, res);
            exp = sb_q.pop_front();
            checks++;
            if (lat !== ((b == 32'd0) ? 2 : 33) || res !== exp) begin
                errors++; $display("FAIL b2b[%0d] %0d %h/%h: got lat %0d res %h expected %h", i, sgn, a, b, lat, res, exp);
            end
            start_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_operand_change();
        test_back_to_back();
        checks++;
        if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
